// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
// cube_pkg : shared FSM state encoding and default operand width for cube.
// Revision : 1.0
// ============================================================================
package cube_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SQ_LD  = 3'd1,
        SQ_RUN = 3'd2,
        CU_LD  = 3'd3,
        CU_RUN = 3'd4,
        FIN    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cube_shmul.sv
`default_nettype none
// ============================================================================
// shmul : iterative shift-add multiplier, 2N-bit a times N-bit b, 3N-bit result.
// Revision : 1.0
// ============================================================================
module shmul #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [2*N-1:0]   a,
    input  logic [N-1:0]     b,
    output logic [3*N-1:0]   product,
    output logic             last
);

    localparam int CW = $clog2(N + 1);

    logic [3*N-1:0] acc;
    logic [3*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;

    // Value the accumulator takes at the end of the current step, so the
    // caller can capture the finished product on the same edge as the last step.
    assign product = mplier[0] ? (acc + mcand) : acc;
    assign last    = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cube.sv
`default_nettype none
// ============================================================================
// cube : computes x^3 by running one shared shift-add multiplier twice.
// Revision : 1.0
// ============================================================================
module cube
    import cube_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     x_i,
    input  logic             start,
    output logic [3*N-1:0]   result,
    output logic             busy,
    output logic             done
);

    state_t         state;
    logic [N-1:0]   x;
    logic [2*N-1:0] sq;

    logic           mul_load;
    logic           mul_step;
    logic           mul_last;
    logic [2*N-1:0] mul_a;
    logic [3*N-1:0] mul_p;

    assign mul_load = (state == SQ_LD)  || (state == CU_LD);
    assign mul_step = (state == SQ_RUN) || (state == CU_RUN);
    assign mul_a    = (state == CU_LD) ? sq : {{N{1'b0}}, x};

    shmul #(.N(N)) u_shmul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (mul_a),
        .b       (x),
        .product (mul_p),
        .last    (mul_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            x      <= '0;
            sq     <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= x_i;
                        busy  <= 1'b1;
                        state <= SQ_LD;
                    end
                end
                SQ_LD:  state <= SQ_RUN;
                SQ_RUN: begin
                    if (mul_last) begin
                        sq    <= mul_p[2*N-1:0];
                        state <= CU_LD;
                    end
                end
                CU_LD:  state <= CU_RUN;
                CU_RUN: begin
                    // result moves only on the edge entering FIN
                    if (mul_last) begin
                        result <= mul_p;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cube.sv
`default_nettype none
// ============================================================================
// tb_cube : randomized and directed scoreboard bench for cube (N = 8).
// Revision : 1.0
// ============================================================================
module tb_cube;

    localparam int N   = 8;
    localparam int LAT = 2 * N + 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    x_i;
    logic            start;
    logic [3*N-1:0]  result;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_result = 64'd0;
    int          rem = 0;
    int          dones_seen = 0;
    int          dones_exp  = 0;

    cube #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .x_i    (x_i),
        .start  (start),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] cube_ref(input logic [N-1:0] v);
        logic [63:0] w;
        w = 64'(v);
        return w * w * w;
    endfunction

    // Monitor: model of an operation as a fixed-length busy window with the
    // done pulse in its last cycle; expected results come from the queue.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            rem = 0;
            exp_q.delete();
            exp_result = 64'd0;
            chk("reset_busy",   64'(busy),   64'd0);
            chk("reset_done",   64'(done),   64'd0);
            chk("reset_result", 64'(result), 64'd0);
        end else begin
            chk("busy", 64'(busy), 64'(rem > 0));
            chk("done", 64'(done), 64'(rem == 1));
            if (done) dones_seen++;
            if (rem == 1) begin
                dones_exp++;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    exp_result = exp_q.pop_front();
                    chk("result_at_done", 64'(result), exp_result);
                end
            end else begin
                chk("result_stable", 64'(result), exp_result);
            end
            if (rem > 0) begin
                rem--;
            end else if (start) begin
                rem = LAT;
                exp_q.push_back(cube_ref(x_i));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (rem != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rem != 0) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [N-1:0] v);
        @(negedge clk);
        x_i   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x_i   = N'($urandom);
        #2;
        wait_idle();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        x_i   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(8'd0);
        run_op(8'd5);
        run_op(8'd9);
        run_op(8'd255);

        // second start while busy must be ignored
        @(negedge clk);
        x_i = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        x_i = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        wait_idle();

        // start held high: back-to-back operations
        @(negedge clk);
        x_i = 8'd2; start = 1'b1;
        repeat (3 * (LAT + 1)) @(negedge clk);
        start = 1'b0;
        #2;
        wait_idle();

        // reset in mid-operation
        @(negedge clk);
        x_i = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(8'd4);

        // random operations with busy-time noise on start and x_i
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x_i   = N'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < LAT; k++) begin
                @(negedge clk);
                x_i   = N'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end
            start = 1'b0;
            #2;
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(dones_seen), 64'(dones_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cube.md
CUBE -- requirements
Module: cube

Interface
REQ-001 Parameter N, default 8: operand width in bits; result width is 3N.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 x_i  input  N  unsigned operand; sampled only on a start acceptance edge.
REQ-005 start  input  1  request; accepted only when FSM is IDLE.
REQ-006 result  output  3N  registered unsigned x^3; holds last completed value.
REQ-007 busy  output  1  high in every FSM state except IDLE.
REQ-008 done  output  1  one-cycle pulse; result is valid and stable while high.

Function
REQ-009 The block SHALL compute result = x_i^3 exactly, unsigned, with no truncation (max (2^N-1)^3 fits 3N bits).
REQ-010 The FSM SHALL have states IDLE, SQ_LD, SQ_RUN, CU_LD, CU_RUN, FIN, in that order.
REQ-011 IDLE -> SQ_LD on a rising edge with start=1; otherwise the FSM SHALL stay in IDLE.
REQ-012 On acceptance, x_i SHALL be latched into an internal N-bit register x; later x_i changes have no effect.
REQ-013 SQ_LD SHALL load the multiplier with a = x zero-extended to 2N bits and b = x, then go to SQ_RUN.
REQ-014 SQ_RUN SHALL last exactly N cycles, one shift-add step per cycle, and produce sq = x*x (2N bits).
REQ-015 CU_LD SHALL load the multiplier with a = sq and b = x, then go to CU_RUN.
REQ-016 CU_RUN SHALL last exactly N cycles, producing a 3N-bit product; on exit, result SHALL be written.
REQ-017 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 Latency: busy SHALL be high for exactly 2N+3 cycles per operation (19 for N=8); done SHALL rise in the last of them.
REQ-019 start while busy SHALL be ignored; no queuing.
REQ-020 start held high continuously SHALL restart on the first IDLE cycle after FIN, giving back-to-back operations with one IDLE cycle between.
REQ-021 result SHALL change only on the edge entering FIN; it SHALL be stable in all other cycles.
REQ-022 The multiplier SHALL be reused for both products; no second multiplier instance.

Reset
REQ-023 rst=0 SHALL immediately force: state IDLE, result 0, busy 0, done 0, and clear internal x, sq and multiplier registers.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no result update; the first start after release SHALL run a full 2N+3-cycle operation.
REQ-025 After reset release, the first rising edge SHALL evaluate start normally.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding constants and the default N.
REQ-027 One sub-module, shmul: iterative shift-add multiplier, 2N-bit a, N-bit b, 3N-bit product; load, N steps, step-count-complete flag; same clk/rst.
REQ-028 The top level SHALL contain only the FSM, the x/sq/result registers, and the shmul instance.

Verification
REQ-029 x_i=0, start pulse -> done after 19 cycles, result=0.
REQ-030 x_i=5 -> result=125; x_i=9 -> result=729; busy high exactly 19 cycles each.
REQ-031 x_i=255 -> result=16581375 (0xFD02FF); no overflow.
REQ-032 x_i=3 with start, then x_i=7 and start pulsed at cycle 5 -> result=27, second start ignored, done asserted once.
REQ-033 start held high, x_i=2 -> results 8 on repeated completions, one IDLE cycle between busy windows.
REQ-034 x_i=200 started, rst=0 at cycle 10 -> busy, done and result immediately 0; after release, x_i=4 -> result=64 after 19 cycles.
